ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the mini CPU's single-port 512x32 `ram`. It shares the `ram` between the instruction-fetch path and the data load/store path using round-robin arbitration. It drives the `ram` `read`/`write`/`addr`/`BusMuxOut` pins, captures `BusMuxIn`, and returns data to the winner over a req/ack handshake. It sits between the control unit and `ram`; it is the only driver of the `ram` control pins.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 39 +++
 rtl/rr_arb2.sv | 25 ++
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// mem_ctrl_pkg: shared widths, sequencer states and port IDs for the ram arbiter (rev 1.0)
package mem_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ram_arbiter_if: requester handshakes plus ram pins; slave side is the arbiter (rev 1.0)
interface ram_arbiter_if #(
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;

  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
    output fetch_ack, fetch_rdata, data_ack, data_rdata,
           ram_read, ram_write, ram_addr, ram_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
    input  fetch_ack, fetch_rdata, data_ack, data_rdata,
           ram_read, ram_write, ram_addr, ram_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// rr_arb2: combinational two-request round-robin grant; pointer lives in the caller (rev 1.0)
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic fetch_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = fetch_req | data_req;
    grant_id    = PORT_FETCH;
    if (fetch_req && data_req) begin
      // Tie goes to whichever port was not served last.
      grant_id = ~last_grant;
    end else if (data_req) begin
      grant_id = PORT_DATA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: round-robin sharing of the single-port ram between fetch and load/store (rev 1.0)
module ram_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic         clock,
  input  logic         clear_n,
  ram_arbiter_if.slave bus
);

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                winner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   fetch_rdata_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                grant_valid;
  logic                grant_id;

  rr_arb2 u_rr_arb2 (
    .fetch_req   (bus.fetch_req),
    .data_req    (bus.data_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? ACK : RESP;
      RESP:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are captured once at grant; later input changes are ignored.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      last_grant <= PORT_DATA;
      winner     <= PORT_FETCH;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (state == IDLE && grant_valid) begin
      last_grant <= grant_id;
      winner     <= grant_id;
      if (grant_id == PORT_DATA) begin
        lat_we    <= bus.data_we;
        lat_addr  <= bus.data_addr;
        lat_wdata <= bus.data_wdata;
      end else begin
        lat_we    <= 1'b0;
        lat_addr  <= bus.fetch_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else if (state == RESP) begin
      if (winner == PORT_FETCH) begin
        fetch_rdata_q <= bus.ram_rdata;
      end else begin
        data_rdata_q  <= bus.ram_rdata;
      end
    end
  end

  // Strobes decode from the async-reset state, so ram_write falls the moment clear_n does.
  assign bus.ram_read    = (state == ISSUE) && !lat_we;
  assign bus.ram_write   = (state == ISSUE) &&  lat_we;
  assign bus.ram_addr    = lat_addr;
  assign bus.ram_wdata   = lat_wdata;
  assign bus.fetch_ack   = (state == ACK) && (winner == PORT_FETCH);
  assign bus.data_ack    = (state == ACK) && (winner == PORT_DATA);
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.busy        = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter: directed self-checking bench with a registered-read ram model (rev 1.0)
module tb_ram_arbiter;

  logic clock;
  logic clear_n;
  int   checks;
  int   errors;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  logic [31:0] mem [0:511];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.ram_write === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_read === 1'b1) bus.ram_rdata <= mem[bus.ram_addr];
  end

  logic prev_fack;
  logic prev_dack;

  always @(negedge clock) begin
    if (clear_n === 1'b1) begin
      checks++;
      if ((bus.ram_read === 1'b1 && bus.ram_write === 1'b1) ||
          (bus.fetch_ack === 1'b1 && prev_fack === 1'b1) ||
          (bus.data_ack === 1'b1 && prev_dack === 1'b1)) begin
        errors++;
        $display("FAIL monitor t=%0t: rd=%b wr=%b fack=%b(prev %b) dack=%b(prev %b) required no overlap, 1-cycle acks",
                 $time, bus.ram_read, bus.ram_write, bus.fetch_ack, prev_fack, bus.data_ack, prev_dack);
      end
    end
    prev_fack = bus.fetch_ack;
    prev_dack = bus.data_ack;
  end

  task automatic data_txn(input logic we, input logic [8:0] addr, input logic [31:0] wd, output int lat);
    @(negedge clock);
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (bus.data_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.data_req = 1'b0;
  endtask

  task automatic fetch_txn(input logic [8:0] addr, output int lat);
    @(negedge clock);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (bus.fetch_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0 || bus.busy !== 1'b0 ||
        bus.fetch_ack !== 1'b0 || bus.data_ack !== 1'b0 || bus.ram_addr !== 9'h000 ||
        bus.ram_wdata !== 32'h0 || bus.fetch_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: rd=%b wr=%b busy=%b fack=%b dack=%b addr=%h wd=%h frd=%h drd=%h required all zero",
               bus.ram_read, bus.ram_write, bus.busy, bus.fetch_ack, bus.data_ack,
               bus.ram_addr, bus.ram_wdata, bus.fetch_rdata, bus.data_rdata);
    end
    clear_n = 1'b1;
  endtask

  task automatic test_store;
    @(negedge clock);
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 9'h005; bus.data_wdata = 32'hDEADBEEF;
    @(negedge clock);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_read !== 1'b0 || bus.ram_addr !== 9'h005 ||
        bus.ram_wdata !== 32'hDEADBEEF || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL store_issue: wr=%b rd=%b addr=%h wd=%h busy=%b required 1 0 005 deadbeef 1",
               bus.ram_write, bus.ram_read, bus.ram_addr, bus.ram_wdata, bus.busy);
    end
    @(negedge clock);
    checks++;
    if (bus.data_ack !== 1'b1 || bus.ram_write !== 1'b0 || bus.fetch_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_ack: dack=%b wr=%b fack=%b required 1 0 0", bus.data_ack, bus.ram_write, bus.fetch_ack);
    end
    bus.data_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.data_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_idle: busy=%b dack=%b required 0 0", bus.busy, bus.data_ack);
    end
  endtask

  task automatic test_load;
    logic [31:0] frd_before;
    frd_before = bus.fetch_rdata;
    @(negedge clock);
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 9'h005;
    @(negedge clock);
    checks++;
    if (bus.ram_read !== 1'b1 || bus.ram_write !== 1'b0 || bus.ram_addr !== 9'h005) begin
      errors++;
      $display("FAIL load_issue: rd=%b wr=%b addr=%h required 1 0 005", bus.ram_read, bus.ram_write, bus.ram_addr);
    end
    @(negedge clock);
    checks++;
    if (bus.ram_read !== 1'b0 || bus.data_ack !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL load_resp: rd=%b dack=%b busy=%b required 0 0 1", bus.ram_read, bus.data_ack, bus.busy);
    end
    @(negedge clock);
    checks++;
    if (bus.data_ack !== 1'b1 || bus.data_rdata !== 32'hDEADBEEF || bus.fetch_rdata !== frd_before) begin
      errors++;
      $display("FAIL load_ack: dack=%b drd=%h frd=%h required 1 deadbeef %h",
               bus.data_ack, bus.data_rdata, bus.fetch_rdata, frd_before);
    end
    bus.data_req = 1'b0;
  endtask

  task automatic test_round_robin;
    int lat;
    int fetch_at[2];
    int data_at;
    int nf;
    logic [31:0] drd_before;
    data_txn(1'b1, 9'h010, 32'h11111111, lat);
    data_txn(1'b1, 9'h020, 32'h22222222, lat);
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rr_reset: busy=%b drd=%h required 0 0", bus.busy, bus.data_rdata);
    end
    clear_n = 1'b1;
    bus.fetch_req = 1'b1; bus.fetch_addr = 9'h010;
    bus.data_req  = 1'b1; bus.data_we = 1'b0; bus.data_addr = 9'h020;
    drd_before = bus.data_rdata;
    nf = 0; data_at = -1; fetch_at[0] = -1; fetch_at[1] = -1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clock);
      if (bus.fetch_ack === 1'b1 && nf < 2) begin
        fetch_at[nf] = i;
        nf++;
        if (nf == 1) begin
          checks++;
          if (bus.fetch_rdata !== 32'h11111111 || bus.data_rdata !== drd_before) begin
            errors++;
            $display("FAIL rr_fetch_data: frd=%h drd=%h required 11111111 %h", bus.fetch_rdata, bus.data_rdata, drd_before);
          end
        end
      end
      if (bus.data_ack === 1'b1 && data_at < 0) begin
        data_at = i;
        checks++;
        if (bus.data_rdata !== 32'h22222222 || bus.fetch_rdata !== 32'h11111111) begin
          errors++;
          $display("FAIL rr_data_data: drd=%h frd=%h required 22222222 11111111", bus.data_rdata, bus.fetch_rdata);
        end
      end
    end
    bus.fetch_req = 1'b0;
    bus.data_req  = 1'b0;
    checks++;
    if (fetch_at[0] != 3 || data_at != 7 || fetch_at[1] != 11) begin
      errors++;
      $display("FAIL rr_order: fetch acks at %0d,%0d data ack at %0d required 3,11 and 7",
               fetch_at[0], fetch_at[1], data_at);
    end
    @(negedge clock);
  endtask

  task automatic test_addr_edges;
    int lat;
    logic [31:0] drd_before;
    data_txn(1'b1, 9'h1FF, 32'hCAFEF00D, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL top_store_latency: %0d required 2", lat);
    end
    drd_before = bus.data_rdata;
    @(negedge clock);
    bus.fetch_req = 1'b1; bus.fetch_addr = 9'h1FF;
    @(negedge clock);
    checks++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 9'h1FF) begin
      errors++;
      $display("FAIL top_fetch_addr: rd=%b addr=%h required 1 1ff", bus.ram_read, bus.ram_addr);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.fetch_ack !== 1'b1 || bus.fetch_rdata !== 32'hCAFEF00D || bus.data_rdata !== drd_before) begin
      errors++;
      $display("FAIL top_fetch_data: fack=%b frd=%h drd=%h required 1 cafef00d %h",
               bus.fetch_ack, bus.fetch_rdata, bus.data_rdata, drd_before);
    end
    bus.fetch_req = 1'b0;
    data_txn(1'b1, 9'h000, 32'h0000A5A5, lat);
    fetch_txn(9'h000, lat);
    checks++;
    if (lat != 3 || bus.fetch_rdata !== 32'h0000A5A5) begin
      errors++;
      $display("FAIL zero_fetch: lat=%0d frd=%h required 3 0000a5a5", lat, bus.fetch_rdata);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int acks_seen;
    data_txn(1'b1, 9'h033, 32'h12345678, lat);
    @(negedge clock);
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 9'h033; bus.data_wdata = 32'h0BADF00D;
    @(negedge clock);
    checks++;
    if (bus.ram_write !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: wr=%b required 1", bus.ram_write);
    end
    #1 clear_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_write !== 1'b0 || bus.busy !== 1'b0 || bus.data_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: wr=%b busy=%b dack=%b required 0 0 0", bus.ram_write, bus.busy, bus.data_ack);
    end
    @(negedge clock);
    bus.data_req = 1'b0;
    clear_n = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.data_ack === 1'b1 || bus.fetch_ack === 1'b1) acks_seen++;
    end
    checks++;
    if (acks_seen != 0) begin
      errors++;
      $display("FAIL abort_no_ack: %0d acks required 0", acks_seen);
    end
    data_txn(1'b0, 9'h033, 32'h0, lat);
    checks++;
    if (lat != 3 || bus.data_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL abort_old_value: lat=%0d drd=%h required 3 12345678", lat, bus.data_rdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_fack = 1'b0;
    prev_dack = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.ram_rdata = '0;
    clear_n = 1'b1;
    #3 clear_n = 1'b0;
    test_reset;
    test_store;
    test_load;
    test_round_robin;
    test_addr_edges;
    test_reset_mid;
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
